// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier, restoring divider, sign fix-up.
// Optional fast-result detection in IDLE is enabled by defining MULDIV_FASTRES_EN.
module muldiv_iter_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sign_a_en, sign_b_en, a_neg, b_neg, b_zero, neg_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    // Operand conditioning: MULHSU treats only a as signed; plain MUL needs no signs at all.
    always_comb begin
        sign_a_en = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sign_b_en = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg     = sign_a_en & a[XLEN-1];
        b_neg     = sign_b_en & b[XLEN-1];
        a_abs     = a_neg ? (~a + 1'b1) : a;
        b_abs     = b_neg ? (~b + 1'b1) : b;
        b_zero    = (b == '0);
        case (op)
            3'd1, 3'd2: neg_in = a_neg ^ b_neg;
            3'd4:       neg_in = (a_neg ^ b_neg) & ~b_zero;
            3'd6:       neg_in = a_neg;
            default:    neg_in = 1'b0;
        endcase
    end

    // hi/lo hold product halves for multiply, remainder/quotient for divide
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign prod_fix  = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    assign quot_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign rem_fix   = neg_q ? (~hi_q + 1'b1) : hi_q;

`ifdef MULDIV_FASTRES_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_val;

    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (!op[2]) begin
            fast_hit = (a == '0) || b_zero;
        end else if (b_zero) begin
            fast_hit = 1'b1;
            fast_val = op[1] ? a : '1;
        end else if (a == '0) begin
            fast_hit = 1'b1;
        end else if (!op[0] && (a == INT_MIN) && (b == '1)) begin
            fast_hit = 1'b1;
            fast_val = op[1] ? '0 : a;
        end else if (op[0] && (b == XLEN'(1))) begin
            fast_hit = 1'b1;
            fast_val = op[1] ? '0 : a;
        end
    end
`endif

    // Control FSM and datapath next-state; kill overrides every transition
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    hi_d    = '0;
                    lo_d    = a_abs;
                    b_d     = b_abs;
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MULDIV_FASTRES_EN
                    if (fast_hit) begin
                        result_d = fast_val;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                case (op_q)
                    3'd0:       result_d = prod_fix[XLEN-1:0];
                    3'd4, 3'd5: result_d = quot_fix;
                    3'd6, 3'd7: result_d = rem_fix;
                    default:    result_d = prod_fix[2*XLEN-1:XLEN];
                endcase
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule
